// File: rtl/falu_pkg.sv
// Shared definitions for the floating-point ALU issue controller:
// op codes, FSM state encoding and the per-op latency lookup.
package falu_pkg;

    localparam logic [2:0] FALU_ADD = 3'b000;
    localparam logic [2:0] FALU_MUL = 3'b001;
    localparam logic [2:0] FALU_DIV = 3'b010;
    localparam logic [2:0] FALU_CMP = 3'b011;
    localparam logic [2:0] FALU_CVT = 3'b100;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= FALU_CVT;
    endfunction

    function automatic logic [CNT_W-1:0] lat_lookup(
        input logic [2:0]       op,
        input logic [CNT_W-1:0] add_lat,
        input logic [CNT_W-1:0] mul_lat,
        input logic [CNT_W-1:0] div_lat,
        input logic [CNT_W-1:0] cmp_lat,
        input logic [CNT_W-1:0] cvt_lat
    );
        case (op)
            FALU_ADD: return add_lat;
            FALU_MUL: return mul_lat;
            FALU_DIV: return div_lat;
            FALU_CMP: return cmp_lat;
            FALU_CVT: return cvt_lat;
            default:  return '0;
        endcase
    endfunction

    // Compares and float-to-int converts (funct7[3]=0) land in the integer file.
    function automatic logic writes_int(input logic [2:0] op, input logic f7_hi);
        return (op == FALU_CMP) || ((op == FALU_CVT) && !f7_hi);
    endfunction

endpackage

// File: rtl/falu_issue_ctrl_if.sv
// Decode, FP register-file, ALU and writeback signals of the issue controller.
// master = issue controller, slave = surrounding pipeline / ALU.
interface falu_issue_ctrl_if #(
    parameter int FLEN = 32
);
    logic            instr_valid;
    logic            instr_ready;
    logic [2:0]      falu_op;
    logic [2:0]      funct3;
    logic [1:0]      funct7_3_2;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [4:0]      frf_rs1_addr;
    logic [4:0]      frf_rs2_addr;
    logic [FLEN-1:0] frf_rs1_data;
    logic [FLEN-1:0] frf_rs2_data;
    logic            flush;
    logic [FLEN-1:0] Rs1;
    logic [FLEN-1:0] Rs2;
    logic [2:0]      FALU_ctrl;
    logic [2:0]      Funct3;
    logic [1:0]      Funct7_3_2;
    logic [FLEN-1:0] alu_result;
    logic            alu_overflow;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [FLEN-1:0] wb_data;
    logic            wb_to_int;
    logic            wb_overflow;
    logic            wb_illegal;

    modport master (
        input  instr_valid, falu_op, funct3, funct7_3_2, rs1_addr, rs2_addr, rd_addr,
               frf_rs1_data, frf_rs2_data, flush, alu_result, alu_overflow,
        output instr_ready, frf_rs1_addr, frf_rs2_addr, Rs1, Rs2, FALU_ctrl, Funct3,
               Funct7_3_2, wb_valid, wb_rd, wb_data, wb_to_int, wb_overflow, wb_illegal
    );

    modport slave (
        output instr_valid, falu_op, funct3, funct7_3_2, rs1_addr, rs2_addr, rd_addr,
               frf_rs1_data, frf_rs2_data, flush, alu_result, alu_overflow,
        input  instr_ready, frf_rs1_addr, frf_rs2_addr, Rs1, Rs2, FALU_ctrl, Funct3,
               Funct7_3_2, wb_valid, wb_rd, wb_data, wb_to_int, wb_overflow, wb_illegal
    );

endinterface

// File: rtl/falu_lat_counter.sv
// Down-counter timing the fixed ALU latency; done marks the final EXEC cycle.
module falu_lat_counter
    import falu_pkg::*;
(
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/falu_issue_ctrl.sv
// Single-outstanding FP ALU issue controller: latch operands, hold them for the
// op latency, capture the result and emit a one-cycle writeback.
//   state   | meaning
//   IDLE    | ready for a decoded instruction
//   EXEC    | operands held on the ALU, latency counter running
//   WB      | writeback strobe for the captured result
module falu_issue_ctrl
    import falu_pkg::*;
#(
    parameter int FLEN    = 32,
    parameter int ADD_LAT = 1,
    parameter int MUL_LAT = 1,
    parameter int DIV_LAT = 12,
    parameter int CMP_LAT = 1,
    parameter int CVT_LAT = 1
) (
    input logic              CLK,
    input logic              rst_n,
    falu_issue_ctrl_if.master bus
);

    if (ADD_LAT < 1 || ADD_LAT > 15 || MUL_LAT < 1 || MUL_LAT > 15 ||
        DIV_LAT < 1 || DIV_LAT > 15 || CMP_LAT < 1 || CMP_LAT > 15 ||
        CVT_LAT < 1 || CVT_LAT > 15) begin : g_bad_lat
        $error("falu_issue_ctrl: every latency parameter must lie in 1..15");
    end

    state_t           state;
    state_t           state_nxt;
    logic             legal;
    logic             accept;
    logic             capture;
    logic             cnt_done;
    logic [CNT_W-1:0] lat_val;

    assign legal   = op_legal(bus.falu_op);
    assign accept  = (state == ST_IDLE) && bus.instr_valid && !bus.flush;
    assign capture = (state == ST_EXEC) && cnt_done && !bus.flush;
    assign lat_val = lat_lookup(bus.falu_op, CNT_W'(ADD_LAT), CNT_W'(MUL_LAT),
                                CNT_W'(DIV_LAT), CNT_W'(CMP_LAT), CNT_W'(CVT_LAT));

    assign bus.frf_rs1_addr = bus.rs1_addr;
    assign bus.frf_rs2_addr = bus.rs2_addr;

    falu_lat_counter u_lat_counter (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .clear    (bus.flush),
        .load     (accept && legal),
        .dec      (state == ST_EXEC),
        .load_val (lat_val),
        .done     (cnt_done)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = legal ? ST_EXEC : ST_WB;
                end
            end
            ST_EXEC: begin
                if (bus.flush) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_done) begin
                    state_nxt = ST_WB;
                end
            end
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.instr_ready = (state == ST_IDLE);
        bus.wb_valid    = (state == ST_WB) && !bus.flush;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            bus.Rs1         <= '0;
            bus.Rs2         <= '0;
            bus.FALU_ctrl   <= '0;
            bus.Funct3      <= '0;
            bus.Funct7_3_2  <= '0;
            bus.wb_rd       <= '0;
            bus.wb_to_int   <= 1'b0;
            bus.wb_data     <= '0;
            bus.wb_overflow <= 1'b0;
            bus.wb_illegal  <= 1'b0;
        end else if (accept) begin
            bus.Rs1        <= bus.frf_rs1_data;
            bus.Rs2        <= bus.frf_rs2_data;
            bus.FALU_ctrl  <= bus.falu_op;
            bus.Funct3     <= bus.funct3;
            bus.Funct7_3_2 <= bus.funct7_3_2;
            bus.wb_rd      <= bus.rd_addr;
            bus.wb_to_int  <= legal && writes_int(bus.falu_op, bus.funct7_3_2[1]);
            // Illegal ops bypass the ALU, so their writeback fields are set here.
            if (!legal) begin
                bus.wb_data     <= '0;
                bus.wb_overflow <= 1'b0;
                bus.wb_illegal  <= 1'b1;
            end
        end else if (capture) begin
            bus.wb_data     <= bus.alu_result;
            bus.wb_overflow <= bus.alu_overflow;
            bus.wb_illegal  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_falu_issue_ctrl.sv
// Self-checking bench for falu_issue_ctrl: directed vector table, random ops
// against a cycle-level reference model, and hand-built flush/reset sequences.
module tb_falu_issue_ctrl;
    import falu_pkg::*;

    localparam int FLEN    = 32;
    localparam int ADD_LAT = 1;
    localparam int MUL_LAT = 1;
    localparam int DIV_LAT = 12;
    localparam int CMP_LAT = 2;
    localparam int CVT_LAT = 3;

    logic CLK   = 1'b0;
    logic rst_n = 1'b0;
    always #5 CLK = ~CLK;

    falu_issue_ctrl_if #(.FLEN(FLEN)) bus ();

    falu_issue_ctrl #(
        .FLEN(FLEN), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT),
        .CMP_LAT(CMP_LAT), .CVT_LAT(CVT_LAT)
    ) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  f3;
        logic [1:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic [31:0] exp_data;
        logic        exp_int;
        logic        exp_ill;
        logic        exp_ovf;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: latency and destination file straight from the op rules.
    function automatic int model_lat(input logic [2:0] op);
        case (op)
            3'd0:    return ADD_LAT;
            3'd1:    return MUL_LAT;
            3'd2:    return DIV_LAT;
            3'd3:    return CMP_LAT;
            3'd4:    return CVT_LAT;
            default: return 0;
        endcase
    endfunction

    function automatic logic model_int(input logic [2:0] op, input logic [1:0] f7);
        return (op == 3'd3) || (op == 3'd4 && f7[1] == 1'b0);
    endfunction

    task automatic drive_instr(input vec_t v);
        bus.instr_valid  = 1'b1;
        bus.falu_op      = v.op;
        bus.funct3       = v.f3;
        bus.funct7_3_2   = v.f7;
        bus.rs1_addr     = v.rs1;
        bus.rs2_addr     = v.rs2;
        bus.rd_addr      = v.rd;
        bus.frf_rs1_data = v.a;
        bus.frf_rs2_data = v.b;
        bus.alu_result   = ~v.res;
        bus.alu_overflow = ~v.ovf;
    endtask

    // Called just after a negedge with the DUT idle; returns one cycle after writeback.
    task automatic run_op(input vec_t v, input string tag);
        int lat;
        lat = model_lat(v.op);
        drive_instr(v);
        #1;
        check({tag, " ready_pre"}, 32'(bus.instr_ready), 32'd1);
        check({tag, " frf_addr"}, {22'd0, bus.frf_rs2_addr, bus.frf_rs1_addr}, {22'd0, v.rs2, v.rs1});
        @(posedge CLK);
        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                bus.instr_valid  = 1'b0;
                bus.frf_rs1_data = ~v.a;
                bus.frf_rs2_data = ~v.b;
            end
            // ALU result is only meaningful on the cycle ending at the capture edge.
            bus.alu_result   = (k == lat) ? v.res : ~v.res;
            bus.alu_overflow = (k == lat) ? v.ovf : ~v.ovf;
            #1;
            if (k <= lat) begin
                check({tag, " exec_wb_valid"}, 32'(bus.wb_valid), 32'd0);
                check({tag, " exec_ready"}, 32'(bus.instr_ready), 32'd0);
                check({tag, " Rs1"}, bus.Rs1, v.a);
                check({tag, " Rs2"}, bus.Rs2, v.b);
                check({tag, " ctrl"}, {24'd0, bus.FALU_ctrl, bus.Funct3, bus.Funct7_3_2},
                      {24'd0, v.op, v.f3, v.f7});
            end else if (k == lat + 1) begin
                check({tag, " wb_valid"}, 32'(bus.wb_valid), 32'd1);
                check({tag, " wb_ready"}, 32'(bus.instr_ready), 32'd0);
                check({tag, " wb_rd"}, 32'(bus.wb_rd), 32'(v.rd));
                check({tag, " wb_data"}, bus.wb_data, v.exp_data);
                check({tag, " wb_flags"}, {29'd0, bus.wb_to_int, bus.wb_overflow, bus.wb_illegal},
                      {29'd0, v.exp_int, v.exp_ovf, v.exp_ill});
            end else begin
                check({tag, " post_wb_valid"}, 32'(bus.wb_valid), 32'd0);
                check({tag, " post_ready"}, 32'(bus.instr_ready), 32'd1);
                check({tag, " wb_data_hold"}, bus.wb_data, v.exp_data);
            end
        end
    endtask

    vec_t tbl[9];
    vec_t v;
    vec_t v2;

    initial begin
        tbl[0] = '{3'b000, 3'b000, 2'b00, 5'd1, 5'd2, 5'd3, 32'h3F80_0000, 32'h4000_0000,
                   32'h4040_0000, 1'b0, 32'h4040_0000, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{3'b001, 3'b111, 2'b00, 5'd2, 5'd3, 5'd4, 32'h4000_0000, 32'h4040_0000,
                   32'h40C0_0000, 1'b1, 32'h40C0_0000, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{3'b000, 3'b000, 2'b01, 5'd4, 5'd5, 5'd5, 32'h0000_0001, 32'h0000_0002,
                   32'h0000_0003, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{3'b010, 3'b000, 2'b00, 5'd6, 5'd2, 5'd6, 32'h40C0_0000, 32'h4000_0000,
                   32'h4040_0000, 1'b0, 32'h4040_0000, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{3'b011, 3'b010, 2'b00, 5'd1, 5'd1, 5'd10, 32'h3F80_0000, 32'h3F80_0000,
                   32'h0000_0001, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{3'b100, 3'b001, 2'b00, 5'd7, 5'd0, 5'd11, 32'h40A0_0000, 32'h0,
                   32'h0000_0005, 1'b0, 32'h0000_0005, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{3'b100, 3'b000, 2'b10, 5'd8, 5'd0, 5'd12, 32'h0000_0005, 32'h0,
                   32'h40A0_0000, 1'b0, 32'h40A0_0000, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{3'b110, 3'b000, 2'b00, 5'd9, 5'd9, 5'd13, 32'h1234_5678, 32'h9ABC_DEF0,
                   32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{3'b101, 3'b011, 2'b11, 5'd3, 5'd4, 5'd14, 32'h0BAD_F00D, 32'h1,
                   32'h5555_5555, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0};

        bus.instr_valid  = 1'b0;
        bus.flush        = 1'b0;
        bus.falu_op      = '0;
        bus.funct3       = '0;
        bus.funct7_3_2   = '0;
        bus.rs1_addr     = '0;
        bus.rs2_addr     = '0;
        bus.rd_addr      = '0;
        bus.frf_rs1_data = '0;
        bus.frf_rs2_data = '0;
        bus.alu_result   = '0;
        bus.alu_overflow = 1'b0;

        @(negedge CLK);
        #1;
        check("reset ready", 32'(bus.instr_ready), 32'd1);
        check("reset wb_valid", 32'(bus.wb_valid), 32'd0);
        check("reset wb_data", bus.wb_data, 32'd0);
        check("reset Rs1", bus.Rs1, 32'd0);
        check("reset flags", {26'd0, bus.FALU_ctrl, bus.wb_to_int, bus.wb_overflow, bus.wb_illegal},
              32'd0);
        @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i], $sformatf("tbl%0d", i));
        end

        // Back-to-back: valid held high, second op must wait for IDLE (cycle 3).
        v  = tbl[1];
        v.ovf = 1'b0;
        v.exp_ovf = 1'b0;
        v2 = tbl[0];
        v2.rd = 5'd21;
        drive_instr(v);
        @(posedge CLK);
        @(negedge CLK);
        drive_instr(v2);
        bus.alu_result   = v.res;
        bus.alu_overflow = 1'b0;
        #1;
        check("b2b ready_c1", 32'(bus.instr_ready), 32'd0);
        @(negedge CLK);
        bus.alu_result = 32'hDEAD_BEEF;
        #1;
        check("b2b wb_valid_c2", 32'(bus.wb_valid), 32'd1);
        check("b2b wb_data_c2", bus.wb_data, 32'h40C0_0000);
        check("b2b ready_c2", 32'(bus.instr_ready), 32'd0);
        @(negedge CLK);
        #1;
        check("b2b ready_c3", 32'(bus.instr_ready), 32'd1);
        @(negedge CLK);
        bus.instr_valid = 1'b0;
        bus.alu_result  = v2.res;
        #1;
        check("b2b ready_c4", 32'(bus.instr_ready), 32'd0);
        check("b2b Rs1_c4", bus.Rs1, v2.a);
        check("b2b ctrl_c4", 32'(bus.FALU_ctrl), 32'(FALU_ADD));
        @(negedge CLK);
        bus.alu_result = 32'hDEAD_BEEF;
        #1;
        check("b2b wb_valid_c5", 32'(bus.wb_valid), 32'd1);
        check("b2b wb_data_c5", bus.wb_data, 32'h4040_0000);
        check("b2b wb_rd_c5", 32'(bus.wb_rd), 32'd21);
        @(negedge CLK);
        #1;
        check("b2b ready_c6", 32'(bus.instr_ready), 32'd1);

        // Flush during cycle 5 of a divide: no writeback, ready again at cycle 6.
        drive_instr(tbl[3]);
        @(posedge CLK);
        for (int k = 1; k <= 15; k++) begin
            @(negedge CLK);
            bus.instr_valid  = 1'b0;
            bus.alu_result   = tbl[3].res;
            bus.alu_overflow = 1'b0;
            bus.flush        = (k == 5);
            #1;
            check($sformatf("flush_div wb_valid c%0d", k), 32'(bus.wb_valid), 32'd0);
            if (k == 5) check("flush_div ready_c5", 32'(bus.instr_ready), 32'd0);
            if (k == 6) check("flush_div ready_c6", 32'(bus.instr_ready), 32'd1);
        end

        // Flush on the writeback cycle suppresses the strobe.
        drive_instr(tbl[0]);
        @(posedge CLK);
        @(negedge CLK);
        bus.instr_valid = 1'b0;
        bus.alu_result  = tbl[0].res;
        @(negedge CLK);
        bus.flush = 1'b1;
        #1;
        check("flush_wb wb_valid", 32'(bus.wb_valid), 32'd0);
        @(negedge CLK);
        bus.flush = 1'b0;
        #1;
        check("flush_wb ready", 32'(bus.instr_ready), 32'd1);
        check("flush_wb wb_valid_after", 32'(bus.wb_valid), 32'd0);

        // Flush in IDLE beats instr_valid.
        drive_instr(tbl[0]);
        bus.flush = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.flush       = 1'b0;
        bus.instr_valid = 1'b0;
        #1;
        check("flush_idle no_accept", 32'(bus.instr_ready), 32'd1);
        @(negedge CLK);
        #1;
        check("flush_idle wb_valid", 32'(bus.wb_valid), 32'd0);

        // Async reset at cycle 4 of a divide.
        v = tbl[3];
        v.f3 = 3'b101;
        v.f7 = 2'b11;
        run_op(tbl[1], "pre_rst");
        drive_instr(v);
        @(posedge CLK);
        for (int k = 1; k <= 16; k++) begin
            @(negedge CLK);
            bus.instr_valid = 1'b0;
            bus.alu_result  = v.res;
            if (k == 4) begin
                rst_n = 1'b0;
                #1;
                check("rst Rs1", bus.Rs1, 32'd0);
                check("rst Rs2", bus.Rs2, 32'd0);
                check("rst ctrl", {24'd0, bus.FALU_ctrl, bus.Funct3, bus.Funct7_3_2}, 32'd0);
                check("rst wb_data", bus.wb_data, 32'd0);
                check("rst wb_misc", {24'd0, bus.wb_rd, bus.wb_to_int, bus.wb_overflow, bus.wb_illegal},
                      32'd0);
                check("rst wb_valid", 32'(bus.wb_valid), 32'd0);
                check("rst ready", 32'(bus.instr_ready), 32'd1);
            end else begin
                if (k == 5) rst_n = 1'b1;
                #1;
                check($sformatf("rst no_wb c%0d", k), 32'(bus.wb_valid), 32'd0);
            end
        end

        // Random ops checked against the reference model.
        for (int i = 0; i < 40; i++) begin
            v.op       = 3'($urandom_range(0, 7));
            v.f3       = 3'($urandom);
            v.f7       = 2'($urandom);
            v.rs1      = 5'($urandom);
            v.rs2      = 5'($urandom);
            v.rd       = 5'($urandom);
            v.a        = $urandom;
            v.b        = $urandom;
            v.res      = $urandom;
            v.ovf      = 1'($urandom);
            v.exp_ill  = (v.op > 3'd4);
            v.exp_data = v.exp_ill ? 32'd0 : v.res;
            v.exp_ovf  = v.exp_ill ? 1'b0 : v.ovf;
            v.exp_int  = model_int(v.op, v.f7);
            run_op(v, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/falu_issue_ctrl.md
Name: falu_issue_ctrl

Overview:
- Initiator side of the floating-point ALU interface. Sits between FP decode/register-file read and the F_ALU execute stage.
- Accepts one decoded FP instruction at a time and latches its operands from the FP register file. Drives the ALU operand/control ports and holds them stable for the op's fixed latency.
- Captures the ALU's registered Result and overflow, then issues a one-cycle writeback to the FP or integer register file.
- Blocking, single outstanding op. Decode stalls while busy.

Parameters:
- FLEN, 32, operand/result width
- ADD_LAT, 1, cycles from ALU inputs valid to Result valid for add/sub (1..15)
- MUL_LAT, 1, same for mul (1..15)
- DIV_LAT, 12, same for div (1..15)
- CMP_LAT, 1, same for compare (1..15)
- CVT_LAT, 1, same for convert (1..15)

Ports:
- CLK  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  decoded FP instruction present
- instr_ready  out  1  block can accept
- falu_op  in  3  op code: 000 add/sub, 001 mul, 010 div, 011 cmp, 100 cvt
- funct3  in  3  instruction funct3
- funct7_3_2  in  2  instruction funct7[3:2]
- rs1_addr  in  5  source 1 index
- rs2_addr  in  5  source 2 index
- rd_addr  in  5  destination index
- frf_rs1_addr  out  5  FP regfile read address 1
- frf_rs2_addr  out  5  FP regfile read address 2
- frf_rs1_data  in  FLEN  async read data 1
- frf_rs2_data  in  FLEN  async read data 2
- flush  in  1  synchronous abort of in-flight op
- Rs1  out  FLEN  ALU operand 1
- Rs2  out  FLEN  ALU operand 2
- FALU_ctrl  out  3  ALU op select
- Funct3  out  3  to ALU
- Funct7_3_2  out  2  to ALU
- alu_result  in  FLEN  ALU Result
- alu_overflow  in  1  ALU overflow
- wb_valid  out  1  writeback strobe
- wb_rd  out  5  writeback index
- wb_data  out  FLEN  writeback data
- wb_to_int  out  1  1: integer regfile (cmp, cvt with funct7_3_2[1]=0), 0: FP regfile
- wb_overflow  out  1  overflow flag for the op
- wb_illegal  out  1  illegal op code (101..111)

Behaviour:
- Reset values: all outputs and registers 0; state IDLE. instr_ready=1 after reset since IDLE drives it high.
- frf_rs1_addr/frf_rs2_addr: combinational copies of rs1_addr/rs2_addr.
- FSM states: IDLE, EXEC, WB.
- IDLE: instr_ready=1. On instr_valid:
  - Latch Rs1, Rs2, FALU_ctrl, Funct3, Funct7_3_2 from frf data and instruction fields; latch rd_addr and wb_to_int.
  - Load cnt with the op's LAT; go to EXEC.
  - Illegal op: skip EXEC, go directly to WB with wb_illegal=1 and wb_data=0.
- EXEC: instr_ready=0. Rs1, Rs2, FALU_ctrl, Funct3 and Funct7_3_2 hold constant. cnt decrements each cycle. On the edge where cnt==1, capture alu_result into wb_data and alu_overflow into wb_overflow; go to WB.
- WB: wb_valid=1 for exactly one cycle with wb_rd, wb_data, wb_to_int, wb_overflow and wb_illegal; instr_ready=0; next state IDLE.
- Latency: accept edge to wb_valid high = LAT+1 cycles. Issue interval = LAT+2 cycles.
- wb_valid=0 outside WB. wb_data, wb_overflow and wb_illegal hold their last values.
- cnt is 4 bits. A LAT of 0 is illegal; the elaboration check fails.
- flush: any state goes to IDLE next cycle; cnt cleared; no wb_valid. In WB, flush suppresses wb_valid. In IDLE, flush overrides instr_valid, so no accept.
- Async reset mid-op: immediate return to IDLE, outputs zeroed, op discarded.

Decomposition:
- Shared package falu_pkg holds:
  - op code constants: FALU_ADD=3'b000, FALU_MUL=3'b001, FALU_DIV=3'b010, FALU_CMP=3'b011, FALU_CVT=3'b100
  - state encoding
  - latency lookup function
- One natural sub-module: falu_lat_counter (load, decrement, done at 1).

Test Plan:
- ADD_LAT=1: f1=0x3F800000, f2=0x40000000, add rd=3 accepted at cycle 0, ALU model returns 0x40400000 -> wb_valid at cycle 2 only, wb_rd=3, wb_data=0x40400000, wb_to_int=0.
- MUL_LAT=1: 0x40000000*0x40400000 -> wb_data=0x40C00000. Second instr_valid held high -> accepted at cycle 3, not earlier.
- DIV_LAT=12, ALU model with 12-cycle result: Rs1/FALU_ctrl stable for 12 EXEC cycles; wb_valid at cycle 13; instr_ready=0 for cycles 1..13.
- cmp op, funct3=010 (feq), equal operands -> wb_data=1, wb_to_int=1. Op code 110 -> wb_valid at cycle 1, wb_illegal=1, wb_data=0.
- flush at cycle 5 of div -> no wb_valid; instr_ready=1 at cycle 6. Reset asserted at cycle 4 of div -> all outputs 0 immediately.
- mul with alu_overflow=1 on final cycle -> wb_overflow=1. Next add -> wb_overflow=0.
